// File: rtl/adder_share_sequencer.sv
// Round-robin sequencer sharing one 32-bit adder among NREQ requesters.
// Each grant runs a WORDS x 32-bit add, one word per cycle, LSW first.
module full_32bit_adder (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

module adder_share_sequencer #(
   parameter int NREQ  = 2,
   parameter int WORDS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*32*WORDS-1:0] a_in,
   input  logic [NREQ*32*WORDS-1:0] b_in,
   input  logic [NREQ-1:0]       cin_in,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic [NREQ-1:0]       done,
   output logic [32*WORDS-1:0]   result,
   output logic                  cout
);
   localparam int W  = 32 * WORDS;
   localparam int PW = $clog2(NREQ);
   localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]              state;
   logic [PW-1:0]           ptr, own, win;
   logic [KW-1:0]           k;
   logic                    carry, any, cin_sel;
   logic [WORDS-1:0][31:0]  a_q, b_q, stage;
   logic [W-1:0]            a_sel, b_sel;
   logic [2*NREQ-1:0]       dbl;
   logic [PW:0]             pos;
   logic [31:0]             sum_w;
   logic                    co_w;

   // Rotate the request vector so bit 0 is the pointer; first set bit wins.
   always_comb begin
      any = 1'b0;
      pos = '0;
      dbl = {req, req} >> ptr;
      for (int i = 0; i < NREQ; i++) begin
         if (!any && dbl[i]) begin
            any = 1'b1;
            pos = {1'b0, ptr} + (PW+1)'(i);
         end
      end
      win = (pos >= (PW+1)'(NREQ)) ? PW'(pos - (PW+1)'(NREQ)) : PW'(pos);
   end

   always_comb begin
      a_sel   = '0;
      b_sel   = '0;
      cin_sel = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (PW'(i) == win) begin
            a_sel   = a_in[i*W +: W];
            b_sel   = b_in[i*W +: W];
            cin_sel = cin_in[i];
         end
      end
   end

   full_32bit_adder u_add (
      .a    (a_q[k]),
      .b    (b_q[k]),
      .cin  (carry),
      .sum  (sum_w),
      .cout (co_w)
   );

   assign busy = (state == RUN) || (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         ptr    <= '0;
         own    <= '0;
         k      <= '0;
         carry  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         stage  <= '0;
         gnt    <= '0;
         done   <= '0;
         result <= '0;
         cout   <= 1'b0;
      end else begin
         done <= '0;
         case (state)
            IDLE: if (any) begin
               state <= RUN;
               gnt   <= NREQ'(1) << win;
               own   <= win;
               a_q   <= a_sel;
               b_q   <= b_sel;
               carry <= cin_sel;
               k     <= '0;
            end
            RUN: begin
               stage[k] <= sum_w;
               carry    <= co_w;
               if (k == KW'(WORDS-1)) begin
                  state <= DONE;
                  k     <= '0;
               end else begin
                  k <= k + 1'b1;
               end
            end
            DONE: begin
               result <= stage;
               cout   <= carry;
               done   <= NREQ'(1) << own;
               gnt    <= '0;
               ptr    <= (own == PW'(NREQ-1)) ? '0 : own + 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adder_share_sequencer.sv
// Randomized bench: two configurations checked against an arithmetic round-robin model.
module tb_adder_share_sequencer;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int ntest = 0, nfail = 0;

   // dut0: NREQ=2, WORDS=2
   logic [1:0]   req0 = '0, cin0 = '0, gnt0, done0;
   logic [127:0] a0 = '0, b0 = '0;
   logic [63:0]  res0;
   logic         busy0, cout0;
   // dut1: NREQ=4, WORDS=1
   logic [3:0]   req1 = '0, cin1 = '0, gnt1, done1;
   logic [127:0] a1 = '0, b1 = '0;
   logic [31:0]  res1;
   logic         busy1, cout1;

   adder_share_sequencer #(.NREQ(2), .WORDS(2)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .a_in(a0), .b_in(b0), .cin_in(cin0),
      .gnt(gnt0), .busy(busy0), .done(done0), .result(res0), .cout(cout0));
   adder_share_sequencer #(.NREQ(4), .WORDS(1)) dut1 (
      .clk(clk), .rst(rst), .req(req1), .a_in(a1), .b_in(b1), .cin_in(cin1),
      .gnt(gnt1), .busy(busy1), .done(done1), .result(res1), .cout(cout1));

   int ptr0 = 0, ptr1 = 0, last_done = -1;
   logic [64:0] prev0 = '0;
   logic [32:0] prev1 = '0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      ntest++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One transaction on dut0; model picks the winner and computes the sum.
   task automatic txn0(input bit drop, input bit gapchk);
      int n, own;
      logic [64:0] exp;
      own = -1;
      for (int i = 0; i < 2; i++) if (own < 0 && req0[(ptr0+i)%2]) own = (ptr0+i)%2;
      n = 0;
      while (gnt0 == 0 && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin chk("accept_timeout0", 1, 0); return; end
      chk("gnt0", gnt0, 2'b1 << own);
      chk("busy0", busy0, 1);
      chk("hold0", {cout0, res0}, prev0);
      exp = {1'b0, a0[own*64 +: 64]} + {1'b0, b0[own*64 +: 64]} + 65'(cin0[own]);
      // operands changed after acceptance must not affect this add
      a0[own*64 +: 64] = {$urandom, $urandom};
      cin0[own] = $urandom_range(0, 1);
      n = 0;
      while (done0 == 0 && n < 50) begin @(posedge clk); #1; n++; end
      chk("lat0", n, 3);
      chk("done0", done0, 2'b1 << own);
      chk("gnt_clr0", gnt0, 0);
      chk("res0", res0, exp[63:0]);
      chk("cout0", cout0, exp[64]);
      if (gapchk && last_done >= 0) chk("gap0", cyc - last_done, 4);
      last_done = cyc;
      prev0 = exp;
      ptr0 = (own + 1) % 2;
      if (drop) req0[own] = 1'b0;
   endtask

   task automatic txn1(input int exp_own);
      int n, own;
      logic [32:0] exp;
      own = -1;
      for (int i = 0; i < 4; i++) if (own < 0 && req1[(ptr1+i)%4]) own = (ptr1+i)%4;
      if (exp_own >= 0) chk("model_own1", own, exp_own);
      n = 0;
      while (gnt1 == 0 && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin chk("accept_timeout1", 1, 0); return; end
      chk("gnt1", gnt1, 4'b1 << own);
      chk("hold1", {cout1, res1}, prev1);
      exp = {1'b0, a1[own*32 +: 32]} + {1'b0, b1[own*32 +: 32]} + 33'(cin1[own]);
      b1[own*32 +: 32] = $urandom;
      n = 0;
      while (done1 == 0 && n < 50) begin @(posedge clk); #1; n++; end
      chk("lat1", n, 2);
      chk("done1", done1, 4'b1 << own);
      chk("res1", res1, exp[31:0]);
      chk("cout1", cout1, exp[32]);
      prev1 = exp;
      ptr1 = (own + 1) % 4;
      req1[own] = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_gnt0", gnt0, 0);   chk("rst_busy0", busy0, 0);
      chk("rst_done0", done0, 0); chk("rst_res0", {cout0, res0}, 0);
      chk("rst_gnt1", gnt1, 0);   chk("rst_res1", {cout1, res1}, 0);
      rst = 1'b0;

      // carry from the low word into the high word
      a0[63:0] = 64'h00000000_FFFFFFFF; b0[63:0] = 64'd1; cin0[0] = 1'b0;
      req0 = 2'b01;
      txn0(1, 0);
      // full ripple through every word
      a0[127:64] = '1; b0[127:64] = '1; cin0[1] = 1'b1;
      req0 = 2'b10;
      txn0(1, 0);
      chk("ripple_res", prev0, {1'b1, 64'hFFFFFFFF_FFFFFFFF});

      // both held: grants alternate, done spacing WORDS+2
      a0 = {$urandom, $urandom, $urandom, $urandom};
      b0 = {$urandom, $urandom, $urandom, $urandom};
      req0 = 2'b11; last_done = -1;
      repeat (4) txn0(0, 1);
      req0 = 2'b00;
      @(negedge clk);

      // reset in the middle of a RUN
      chk("ptr_before_rst", ptr0, 0);
      req0 = 2'b10;
      @(posedge clk); #1;
      chk("rst_mid_gnt", gnt0, 2'b10);
      @(posedge clk); #1;
      rst = 1'b1; #1;
      chk("rst_mid_gnt_clr", gnt0, 0);
      chk("rst_mid_busy", busy0, 0);
      chk("rst_mid_res", {cout0, res0}, 0);
      repeat (3) begin @(posedge clk); #1; chk("rst_mid_nodone", done0, 0); end
      ptr0 = 0; prev0 = '0;
      req0 = 2'b11;
      @(negedge clk); rst = 1'b0;
      txn0(1, 0);
      chk("after_rst_owner", ptr0, 1);
      txn0(1, 0);

      for (int it = 0; it < 24; it++) begin
         for (int p = 0; p < 2; p++) if (!req0[p] && $urandom_range(0, 1)) begin
            req0[p] = 1'b1;
            if ($urandom_range(0, 3) == 0) begin a0[p*64 +: 64] = '1; b0[p*64 +: 64] = '1; end
            else begin a0[p*64 +: 64] = {$urandom, $urandom}; b0[p*64 +: 64] = {$urandom, $urandom}; end
            cin0[p] = $urandom_range(0, 1);
         end
         if (req0 == 0) req0[$urandom_range(0, 1)] = 1'b1;
         txn0(1, 0);
      end

      // 4-port, single-word configuration
      a1[63:32] = 32'hFFFFFFFF; b1[63:32] = 32'h1; cin1[1] = 1'b0;
      req1 = 4'b0010;
      txn1(1);
      a1 = {$urandom, $urandom, $urandom, $urandom};
      b1 = {$urandom, $urandom, $urandom, $urandom};
      req1 = 4'b1010;
      txn1(3);
      txn1(1);
      for (int it = 0; it < 12; it++) begin
         for (int p = 0; p < 4; p++) if (!req1[p] && $urandom_range(0, 1)) begin
            req1[p] = 1'b1;
            a1[p*32 +: 32] = $urandom; b1[p*32 +: 32] = $urandom; cin1[p] = $urandom_range(0, 1);
         end
         if (req1 == 0) req1[$urandom_range(0, 3)] = 1'b1;
         txn1(-1);
      end

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end
endmodule
